// File: rtl/regfile_multiport_if.sv
// Register file access bundle: decode-side read ports plus writeback write port.
// Latency: n/a (wires only). Backpressure: none; ready gates use of the file.
// Ports: master = pipeline (drives enables/addresses/write data), slave = register file.
interface regfile_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) ();
  logic [NUM_READ-1:0]            read_en;
  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic                           write_enable;
  logic [ADDR_WIDTH-1:0]          addr_rd;
  logic [DATA_WIDTH-1:0]          data_rd;
  logic                           ready;

  modport master (
    output read_en, read_addr, write_enable, addr_rd, data_rd,
    input  read_data, ready
  );

  modport slave (
    input  read_en, read_addr, write_enable, addr_rd, data_rd,
    output read_data, ready
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read, single-write integer register file with post-reset clear sequencer.
// Latency: 1 cycle read (registered); write visible next cycle, or same cycle via bypass.
// Backpressure: none; accesses are ignored until ready rises after the clear sweep.
// Ports: clock, reset (sync, active-low), bus (slave modport: read_en/read_addr/read_data,
//        write_enable/addr_rd/data_rd, ready).
module regfile_multiport #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    NUM_READ   = 2,
  parameter int                    ZERO_REG   = 1,
  parameter int                    BYPASS     = 1,
  parameter int                    SP_INDEX   = 2,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h01001000
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_multiport_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   rdata_q [NUM_READ];
  logic [DATA_WIDTH-1:0]   rdata_d [NUM_READ];
  logic [ADDR_WIDTH-1:0]   raddr   [NUM_READ];

  // Storage carries no reset so it can map onto block RAM; the clear
  // sequencer defines every entry before ready is raised.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    wr_live;

  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      raddr[p] = bus.read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    // A write to the hardwired-zero entry never lands, so it must not bypass either.
    wr_live   = bus.write_enable && !(ZERO_REG != 0 && bus.addr_rd == '0);

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (cnt_q == ADDR_WIDTH'(SP_INDEX)) ? SP_INIT : '0;
        for (int p = 0; p < NUM_READ; p++) begin
          rdata_d[p] = '0;
        end
        // Counter parks on the last index rather than wrapping.
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        mem_we    = wr_live;
        mem_waddr = bus.addr_rd;
        mem_wdata = bus.data_rd;
        for (int p = 0; p < NUM_READ; p++) begin
          if (bus.read_en[p]) begin
            if (ZERO_REG != 0 && raddr[p] == '0) begin
              rdata_d[p] = '0;
            end else if (BYPASS != 0 && wr_live && bus.addr_rd == raddr[p]) begin
              rdata_d[p] = bus.data_rd;
            end else begin
              rdata_d[p] = mem[raddr[p]];
            end
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int p = 0; p < NUM_READ; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      for (int p = 0; p < NUM_READ; p++) begin
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ready = ready_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
  end
endmodule
